// File: rtl/sram_bank_array_ctrl.sv
// Multi-bank single-port SRAM array shared by a core port (0) and a DMA port (1).
// Requests are steered to a bank by address decode. Same-bank collisions are
// resolved per bank by a round-robin pointer. Read data returns after a fixed
// two-stage registered pipeline.
module sram_bank_array_ctrl #(
    parameter int unsigned NUM_BANKS      = 4,
    parameter int unsigned WORDS_PER_BANK = 2048,
    parameter int unsigned DATA_W         = 32,
    parameter int unsigned INTERLEAVE     = 1,
    parameter int unsigned ADDR_W         = $clog2(NUM_BANKS * WORDS_PER_BANK)
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic [1:0]             i_req_valid,
    output logic [1:0]             o_req_ready,
    input  logic [1:0]             i_req_we,
    input  logic [1:0][ADDR_W-1:0] i_req_addr,
    input  logic [1:0][DATA_W/8-1:0] i_req_be,
    input  logic [1:0][DATA_W-1:0] i_req_wdata,
    output logic [1:0]             o_rsp_valid,
    output logic [1:0][DATA_W-1:0] o_rsp_rdata
);

    localparam int unsigned BE_W   = DATA_W / 8;
    localparam int unsigned ROW_W  = $clog2(WORDS_PER_BANK);
    localparam int unsigned BANK_W = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;

    logic [1:0][BANK_W-1:0] w_bank;
    logic [1:0][ROW_W-1:0]  w_row;
    logic                   w_same;
    logic [1:0]             w_grant;
    logic [1:0]             w_acc;

    logic [NUM_BANKS-1:0]   r_rr;
    logic [NUM_BANKS-1:0]   r_s1_valid;
    logic [NUM_BANKS-1:0]   r_s1_we;
    logic [NUM_BANKS-1:0]   r_s1_tag;
    logic [ROW_W-1:0]       r_s1_row   [NUM_BANKS];
    logic [BE_W-1:0]        r_s1_be    [NUM_BANKS];
    logic [DATA_W-1:0]      r_s1_wdata [NUM_BANKS];
    logic [DATA_W-1:0]      r_bank_rdata [NUM_BANKS];
    logic [DATA_W-1:0]      r_mem [NUM_BANKS][WORDS_PER_BANK];
    logic [NUM_BANKS-1:0]   r_s2_valid;
    logic [NUM_BANKS-1:0]   r_s2_tag;
    logic [1:0]             r_rsp_valid;
    logic [1:0][DATA_W-1:0] r_rsp_rdata;

    // Address decode: bank select from low bits (interleaved) or high bits (contiguous)
    for (genvar p = 0; p < 2; p++) begin : g_dec
        if (NUM_BANKS == 1) begin : g_single
            assign w_bank[p] = '0;
            assign w_row[p]  = i_req_addr[p][ROW_W-1:0];
        end else if (INTERLEAVE != 0) begin : g_interleave
            assign w_bank[p] = i_req_addr[p][BANK_W-1:0];
            assign w_row[p]  = i_req_addr[p][ADDR_W-1:BANK_W];
        end else begin : g_contig
            assign w_bank[p] = i_req_addr[p][ADDR_W-1:ROW_W];
            assign w_row[p]  = i_req_addr[p][ROW_W-1:0];
        end
    end

    // Arbitration: on a same-bank collision the bank's rr pointer picks the winner
    always_comb begin
        w_same      = i_req_valid[0] & i_req_valid[1] & (w_bank[0] == w_bank[1]);
        w_grant[0]  = i_req_valid[0] & (~w_same | ~r_rr[w_bank[0]]);
        w_grant[1]  = i_req_valid[1] & (~w_same |  r_rr[w_bank[1]]);
        w_acc       = w_grant & {2{~i_rst}};
        o_req_ready = {2{~i_rst}} & (~i_req_valid | w_grant);
    end

    // Stage 1: capture accepted request per bank; flip rr toward the loser on a contest
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_rr       <= '0;
            r_s1_valid <= '0;
            r_s1_we    <= '0;
            r_s1_tag   <= '0;
            for (int unsigned b = 0; b < NUM_BANKS; b++) begin
                r_s1_row[b]   <= '0;
                r_s1_be[b]    <= '0;
                r_s1_wdata[b] <= '0;
            end
        end else begin
            for (int unsigned b = 0; b < NUM_BANKS; b++) begin
                r_s1_valid[b] <= 1'b0;
                for (int unsigned p = 0; p < 2; p++) begin
                    if (w_acc[p] && (w_bank[p] == BANK_W'(b))) begin
                        r_s1_valid[b] <= 1'b1;
                        r_s1_we[b]    <= i_req_we[p];
                        r_s1_tag[b]   <= 1'(p);
                        r_s1_row[b]   <= w_row[p];
                        r_s1_be[b]    <= i_req_be[p];
                        r_s1_wdata[b] <= i_req_wdata[p];
                    end
                end
                if (w_same && (w_bank[0] == BANK_W'(b))) begin
                    r_rr[b] <= ~r_rr[b];
                end
            end
        end
    end

    // Bank macros: byte-masked write or synchronous read; contents survive reset
    always_ff @(posedge i_clk) begin
        for (int unsigned b = 0; b < NUM_BANKS; b++) begin
            if (r_s1_valid[b]) begin
                if (r_s1_we[b]) begin
                    for (int unsigned k = 0; k < BE_W; k++) begin
                        if (r_s1_be[b][k]) begin
                            r_mem[b][r_s1_row[b]][8*k +: 8] <= r_s1_wdata[b][8*k +: 8];
                        end
                    end
                end else begin
                    r_bank_rdata[b] <= r_mem[b][r_s1_row[b]];
                end
            end
        end
    end

    // Stage 2: track which banks hold read data and for which port
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_s2_valid <= '0;
            r_s2_tag   <= '0;
        end else begin
            r_s2_valid <= r_s1_valid & ~r_s1_we;
            r_s2_tag   <= r_s1_tag;
        end
    end

    // Response registers: each port receives at most one bank's data per cycle
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_rsp_valid <= '0;
            r_rsp_rdata <= '0;
        end else begin
            for (int unsigned p = 0; p < 2; p++) begin
                r_rsp_valid[p] <= 1'b0;
                for (int unsigned b = 0; b < NUM_BANKS; b++) begin
                    if (r_s2_valid[b] && (r_s2_tag[b] == 1'(p))) begin
                        r_rsp_valid[p] <= 1'b1;
                        r_rsp_rdata[p] <= r_bank_rdata[b];
                    end
                end
            end
        end
    end

    assign o_rsp_valid = r_rsp_valid;
    assign o_rsp_rdata = r_rsp_rdata;

endmodule

// File: tb/tb_sram_bank_array_ctrl.sv
// Scoreboard bench for sram_bank_array_ctrl: two instances (interleaved and
// contiguous) run side by side against a flat-array memory model.
module tb_sram_bank_array_ctrl;

    localparam int NB  = 4;
    localparam int WPB = 2048;
    localparam int DW  = 32;
    localparam int AW  = 13;
    localparam int BEW = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [1:0]            req_valid [2];
    logic [1:0]            req_ready [2];
    logic [1:0]            req_we    [2];
    logic [1:0][AW-1:0]    req_addr  [2];
    logic [1:0][BEW-1:0]   req_be    [2];
    logic [1:0][DW-1:0]    req_wdata [2];
    logic [1:0]            rsp_valid [2];
    logic [1:0][DW-1:0]    rsp_rdata [2];

    sram_bank_array_ctrl #(.NUM_BANKS(NB), .WORDS_PER_BANK(WPB), .DATA_W(DW), .INTERLEAVE(1)) u_dut_i (
        .i_clk(clk), .i_rst(rst),
        .i_req_valid(req_valid[0]), .o_req_ready(req_ready[0]), .i_req_we(req_we[0]),
        .i_req_addr(req_addr[0]), .i_req_be(req_be[0]), .i_req_wdata(req_wdata[0]),
        .o_rsp_valid(rsp_valid[0]), .o_rsp_rdata(rsp_rdata[0])
    );

    sram_bank_array_ctrl #(.NUM_BANKS(NB), .WORDS_PER_BANK(WPB), .DATA_W(DW), .INTERLEAVE(0)) u_dut_c (
        .i_clk(clk), .i_rst(rst),
        .i_req_valid(req_valid[1]), .o_req_ready(req_ready[1]), .i_req_we(req_we[1]),
        .i_req_addr(req_addr[1]), .i_req_be(req_be[1]), .i_req_wdata(req_wdata[1]),
        .o_rsp_valid(rsp_valid[1]), .o_rsp_rdata(rsp_rdata[1])
    );

    typedef struct {
        bit [31:0] data;
        bit        chk;
        int        due;
    } exp_t;

    bit [31:0] mem_m [int];
    bit        rr_m  [2][NB];
    exp_t      q     [4][$];
    int        checks = 0;
    int        errors = 0;
    int        cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int bank_of(input int d, input int a);
        return (d == 0) ? (a % NB) : (a / WPB);
    endfunction

    task automatic clear_inputs();
        for (int d = 0; d < 2; d++) begin
            req_valid[d] = '0;
            req_we[d]    = '0;
            req_addr[d]  = '0;
            req_be[d]    = '0;
            req_wdata[d] = '0;
        end
    endtask

    task automatic setp(input int d, input int p, input bit we, input int a,
                        input bit [3:0] be, input bit [31:0] wd);
        req_valid[d][p] = 1'b1;
        req_we[d][p]    = we;
        req_addr[d][p]  = AW'(a);
        req_be[d][p]    = be;
        req_wdata[d][p] = wd;
    endtask

    // One cycle: check ready against the model, book accepted work, clock, idle inputs
    task automatic step(output bit [1:0] acc0, output bit [1:0] acc1);
        bit [1:0] acc [2];
        #1;
        for (int d = 0; d < 2; d++) begin
            bit [1:0] exp_rdy;
            int b0;
            int b1;
            b0 = bank_of(d, int'(req_addr[d][0]));
            b1 = bank_of(d, int'(req_addr[d][1]));
            exp_rdy = 2'b11;
            if (req_valid[d][0] && req_valid[d][1] && b0 == b1) begin
                if (rr_m[d][b0]) exp_rdy[0] = 1'b0;
                else             exp_rdy[1] = 1'b0;
                rr_m[d][b0] = !rr_m[d][b0];
            end
            checks++;
            if (req_ready[d] !== exp_rdy) begin
                errors++;
                $display("FAIL ready dut%0d cyc%0d: got %b want %b", d, cyc, req_ready[d], exp_rdy);
            end
            acc[d] = req_valid[d] & exp_rdy;
            for (int p = 0; p < 2; p++) begin
                if (acc[d][p]) begin
                    int key;
                    key = d * 65536 + int'(req_addr[d][p]);
                    if (req_we[d][p]) begin
                        bit [31:0] w;
                        w = mem_m.exists(key) ? mem_m[key] : 32'h0;
                        for (int k = 0; k < 4; k++)
                            if (req_be[d][p][k]) w[8*k +: 8] = req_wdata[d][p][8*k +: 8];
                        if (mem_m.exists(key) || req_be[d][p] == 4'hF) mem_m[key] = w;
                    end else begin
                        exp_t e;
                        e.chk  = mem_m.exists(key);
                        e.data = e.chk ? mem_m[key] : 32'h0;
                        e.due  = cyc + 3;
                        q[d*2+p].push_back(e);
                    end
                end
            end
        end
        acc0 = acc[0];
        acc1 = acc[1];
        @(posedge clk);
        @(negedge clk);
        clear_inputs();
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Monitor: compare every response pulse with the head of its port's queue
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            for (int p = 0; p < 2; p++) begin
                int   i;
                exp_t e;
                i = d * 2 + p;
                if (rsp_valid[d][p] === 1'b1) begin
                    checks++;
                    if (q[i].size() == 0) begin
                        errors++;
                        $display("FAIL rsp_unexpected dut%0d port%0d cyc%0d: got rsp_valid=1 want 0", d, p, cyc);
                    end else begin
                        e = q[i].pop_front();
                        if (e.due != cyc || (e.chk && rsp_rdata[d][p] !== e.data)) begin
                            errors++;
                            $display("FAIL rsp_data dut%0d port%0d: got %h at cyc%0d want %h at cyc%0d",
                                     d, p, rsp_rdata[d][p], cyc, e.data, e.due);
                        end
                    end
                end else if (q[i].size() > 0 && q[i][0].due <= cyc) begin
                    checks++;
                    errors++;
                    $display("FAIL rsp_missing dut%0d port%0d: got no rsp at cyc%0d want rsp at cyc%0d",
                             d, p, cyc, q[i][0].due);
                    void'(q[i].pop_front());
                end
            end
        end
    end

    task automatic check_reset_outputs(input string tag);
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (req_ready[d] !== 2'b00 || rsp_valid[d] !== 2'b00) begin
                errors++;
                $display("FAIL %s dut%0d: got ready=%b rsp_valid=%b want 00/00", tag, d, req_ready[d], rsp_valid[d]);
            end
        end
    endtask

    initial begin
        bit [1:0] a0, a1;
        int       idx [2];
        bit       done;
        clear_inputs();
        rst = 1'b1;

        // Reset: ready low even with requests pending, responses idle and zero
        for (int d = 0; d < 2; d++) req_valid[d] = 2'b11;
        repeat (3) begin
            @(negedge clk);
            check_reset_outputs("reset_outputs");
        end
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (rsp_rdata[d] !== '0) begin
                errors++;
                $display("FAIL reset_rdata dut%0d: got %h want 0", d, rsp_rdata[d]);
            end
        end
        clear_inputs();
        rst = 1'b0;

        // Basic write then read of address 5
        for (int d = 0; d < 2; d++) setp(d, 0, 1'b1, 5, 4'hF, 32'hDEADBEEF);
        step(a0, a1);
        for (int d = 0; d < 2; d++) setp(d, 0, 1'b0, 5, 4'h0, 32'h0);
        step(a0, a1);
        idle(4);

        // Preload a small address pool so random reads have known data
        for (int r = 0; r < 16; r++) begin
            setp(0, 0, 1'b1, r, 4'hF, $urandom);
            setp(1, 0, 1'b1, (r / 4) * WPB + (r % 4), 4'hF, $urandom);
            step(a0, a1);
        end

        // Byte masking
        for (int d = 0; d < 2; d++) setp(d, 0, 1'b1, 9, 4'hF, 32'h11223344);
        step(a0, a1);
        for (int d = 0; d < 2; d++) setp(d, 0, 1'b1, 9, 4'h5, 32'hAABBCCDD);
        step(a0, a1);
        for (int d = 0; d < 2; d++) setp(d, 0, 1'b0, 9, 4'h0, 32'h0);
        step(a0, a1);
        checks++;
        if (mem_m[9] !== 32'h11BB33DD) begin
            errors++;
            $display("FAIL bytemask_model: got %h want 11bb33dd", mem_m[9]);
        end
        idle(4);

        // Sustained contention on bank 0: grants alternate starting with port 0
        idx[0] = 0;
        idx[1] = 0;
        for (int c = 0; c < 6; c++) begin
            for (int p = 0; p < 2; p++) begin
                if (idx[p] < 3) begin
                    setp(0, p, 1'b0, idx[p] * 4, 4'h0, 32'h0);
                    setp(1, p, 1'b0, idx[p], 4'h0, 32'h0);
                end
            end
            step(a0, a1);
            checks++;
            if (a0 !== ((c % 2 == 0) ? 2'b01 : 2'b10)) begin
                errors++;
                $display("FAIL contend_grant c%0d: got %b want %b", c, a0, (c % 2 == 0) ? 2'b01 : 2'b10);
            end
            for (int p = 0; p < 2; p++) if (a0[p]) idx[p]++;
        end
        idle(4);

        // Different banks: both accepted together, responses in the same cycle
        setp(0, 0, 1'b0, 0, 4'h0, 32'h0);
        setp(0, 1, 1'b0, 1, 4'h0, 32'h0);
        setp(1, 0, 1'b0, 0, 4'h0, 32'h0);
        setp(1, 1, 1'b0, WPB, 4'h0, 32'h0);
        step(a0, a1);
        checks++;
        if (a0 !== 2'b11 || a1 !== 2'b11) begin
            errors++;
            $display("FAIL parallel_accept: got %b/%b want 11/11", a0, a1);
        end
        idle(4);

        // Read-after-write across ports on consecutive cycles
        for (int d = 0; d < 2; d++) setp(d, 1, 1'b1, 7, 4'hF, 32'h5A5A5A5A);
        step(a0, a1);
        for (int d = 0; d < 2; d++) setp(d, 0, 1'b0, 7, 4'h0, 32'h0);
        step(a0, a1);
        idle(4);

        // Randomized traffic on the preloaded pool
        for (int c = 0; c < 400; c++) begin
            for (int p = 0; p < 2; p++) begin
                if ($urandom_range(3) != 0)
                    setp(0, p, ($urandom_range(2) == 0), int'($urandom_range(15)),
                         4'($urandom), $urandom);
                if ($urandom_range(3) != 0)
                    setp(1, p, ($urandom_range(2) == 0),
                         int'($urandom_range(3)) * WPB + int'($urandom_range(3)),
                         4'($urandom), $urandom);
            end
            step(a0, a1);
        end
        idle(6);

        // Reset one cycle after a read is accepted: that read never answers
        for (int d = 0; d < 2; d++) setp(d, 0, 1'b0, 3, 4'h0, 32'h0);
        step(a0, a1);
        step(a0, a1);
        rst = 1'b1;
        for (int i = 0; i < 4; i++) q[i].delete();
        for (int d = 0; d < 2; d++) for (int b = 0; b < NB; b++) rr_m[d][b] = 1'b0;
        #1;
        check_reset_outputs("midflight_reset");
        idle(2);
        rst = 1'b0;
        idle(4);

        // After reset a contested bank goes to port 0 first
        setp(0, 0, 1'b0, 0, 4'h0, 32'h0);
        setp(0, 1, 1'b0, 4, 4'h0, 32'h0);
        setp(1, 0, 1'b0, 0, 4'h0, 32'h0);
        setp(1, 1, 1'b0, 1, 4'h0, 32'h0);
        step(a0, a1);
        checks++;
        if (a0 !== 2'b01 || a1 !== 2'b01) begin
            errors++;
            $display("FAIL post_reset_grant: got %b/%b want 01/01", a0, a1);
        end

        // Drain with a bounded wait
        done = 1'b0;
        for (int c = 0; c < 20 && !done; c++) begin
            @(negedge clk);
            done = (q[0].size() == 0) && (q[1].size() == 0) && (q[2].size() == 0) && (q[3].size() == 0);
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL drain_timeout: got %0d/%0d/%0d/%0d pending want 0",
                     q[0].size(), q[1].size(), q[2].size(), q[3].size());
        end
        idle(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sram_bank_array_ctrl.md
# sram_bank_array_ctrl

Parametrised multi-bank SRAM subsystem with two independent request ports (core and DMA) sharing a set of single-port banks of 2048x32 words each. Each request is steered to a bank by address decoding. Bank collisions are resolved by a per-bank round-robin arbiter. Byte-masked writes are supported, and read data returns through a fixed-latency registered pipeline. The block replaces direct single-macro instantiation in the memory hierarchy, giving the core and the DMA concurrent access whenever they target different banks.

## Interface
Parameters:
- NUM_BANKS, 4, number of banks; power of two, at least 1.
- WORDS_PER_BANK, 2048, depth of each bank; power of two.
- DATA_W, 32, word width; multiple of 8.
- INTERLEAVE, 1, bank-select position: 1 means the bank is the low address bits (word-interleaved), 0 means the bank is the high address bits (contiguous).
- ADDR_W, derived as clog2(NUM_BANKS*WORDS_PER_BANK); word address width.

Ports (p = 0 for core, 1 for DMA; every per-port signal exists for both ports):
- CLK, input, 1, single clock. All state updates on the rising edge.
- RST, input, 1, asynchronous, active-high reset.
- p_req_valid, input, 1, request present.
- p_req_ready, output, 1, request accepted this cycle when valid is also high.
- p_req_we, input, 1, 1 means write, 0 means read.
- p_req_addr, input, ADDR_W, word address.
- p_req_be, input, DATA_W/8, byte enables; ignored on reads.
- p_req_wdata, input, DATA_W, write data.
- p_rsp_valid, output, 1, read data valid. Single-cycle pulse; no backpressure.
- p_rsp_rdata, output, DATA_W, read data.

## Operation
- Bank decode:
  - INTERLEAVE=1: bank is addr[log2(NUM_BANKS)-1:0] and the row is the remaining upper bits.
  - INTERLEAVE=0: bank is the top log2(NUM_BANKS) bits and the row is the lower bits.
  - NUM_BANKS=1: bank index is constant 0.
- Each bank is single-port, with a one-cycle synchronous read and a byte-masked write. Contents are not reset.
- Arbitration, per bank, combinational within the cycle:
  - If only one port targets the bank, that port is granted.
  - If both ports target the same bank, the port indicated by that bank's rr_ptr is granted and the other port's req_ready is 0.
  - rr_ptr toggles only on a contested grant. It moves to the losing port, so that port wins the next contest.
  - rr_ptr reset value is 0 (core first).
- p_req_ready is 1 when p_req_valid is low or the port is granted, and 0 during reset. It never depends on the response path.
- Two ports hitting different banks are both accepted in the same cycle.
- Accepted request (valid and ready at edge T):
  - Bank inputs (row, we, be, wdata, port tag) are registered at edge T.
  - The bank performs the access at edge T+1.
  - For a read, read data and the port tag are registered at edge T+2.
  - The matching p_rsp_valid is high for exactly the cycle following edge T+2.
- Writes produce no response. Bytes with be=0 keep their old value. An all-zero be is a legal no-op write.
- Ordering:
  - Per port, responses return in acceptance order.
  - A read accepted the cycle after a write to the same address returns the new data.
  - Same-cycle same-bank requests are serialised: the winner's access is performed first.
- Reset asserted mid-operation:
  - In-flight pipeline entries are discarded, and rsp_valid is 0 immediately (asynchronously).
  - rr_ptr returns to 0.
  - Bank contents are undefined-preserved, i.e. not modified by reset.
  - No response is generated for requests accepted before reset.

## Timing
- Reset values: p_req_ready=0, p_rsp_valid=0, p_rsp_rdata=0, all rr_ptr=0, all pipeline valid bits 0.
- Read latency is fixed at 2 cycles from the acceptance edge to the rsp_valid cycle. There is no variable latency.
- Throughput is one request per port per cycle when the ports target different banks. Sustained same-bank contention gives each port 50% of the bank's bandwidth.
- p_rsp_rdata holds its last value when p_rsp_valid=0.
- No combinational path exists from any req input to any rsp output.

## Test plan
- Reset and basic access: hold RST for 3 cycles, then port 0 writes 0xDEADBEEF to address 5, then reads address 5. Required: ready=0 during reset; the write is accepted the first cycle after reset; rsp_valid pulses exactly 2 cycles after the read is accepted, with rdata 0xDEADBEEF.
- Byte masking: write 0x11223344 with be=0xF, then write 0xAABBCCDD with be=0x5 to the same address, then read it. Required: rdata 0x11BB33DD.
- Bank conflict, INTERLEAVE=1, NUM_BANKS=4: both ports continuously read addresses 0, 4, 8 and so on (all bank 0) for 6 cycles. Required: grants alternate 0,1,0,1,0,1; the loser sees ready=0; each port receives 3 responses, in order and with correct data.
- Parallel banks: port 0 reads address 0 (bank 0) while port 1 reads address 1 (bank 1) in the same cycle. Required: both ready=1 and both rsp_valid pulses land in the same cycle. Repeat with INTERLEAVE=0, addresses 0 and 2048: same result.
- Read-after-write: port 1 writes 0x5A5A5A5A to address 7 at cycle T, and port 0 reads address 7 at T+1. Required: port 0 gets 0x5A5A5A5A.
- Reset mid-flight: accept a read, then assert RST 1 cycle later. Required: no rsp_valid ever appears for that read. After reset, a contested access grants port 0 first.
